von_neumann_core: RTL and testbench



---
 rtl/von_neumann_core.sv | 140 ++++++++++++++
 tb/tb_von_neumann_core.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/von_neumann_core.sv
// Multi-cycle 16-bit CPU with one shared 256x16 instruction/data memory.
// Optional macro HALT_FINISH_EN: report and end simulation on the first cycle with halt=1.
module von_neumann_core (
  input  logic        clock,
  input  logic        reset,
  input  logic        ext_we,
  input  logic [7:0]  ext_addr,
  input  logic [15:0] ext_wdata,
  input  logic [2:0]  dbg_raddr,
  output logic [15:0] dbg_rdata,
  output logic [7:0]  pc,
  output logic [15:0] ir,
  output logic        halt
);

  typedef enum logic [2:0] {StFetch, StDecode, StExecute, StMemwb, StHalt} state_e;

  state_e      r_state, w_state_d;
  logic [7:0]  r_pc, w_pc_d;
  logic [15:0] r_ir;
  logic [15:0] r_regs [8];
  logic [15:0] r_mem [256];
  logic [15:0] r_rdata;

  logic [3:0]  w_op;
  logic [2:0]  w_rd, w_rs1, w_rs2;
  logic [15:0] w_imm6, w_a, w_b, w_d, w_alu;
  logic [7:0]  w_imm8;
  logic        w_ir_load, w_rf_we, w_core_we;
  logic [15:0] w_rf_wdata;
  logic [7:0]  w_core_addr;
  logic        w_mem_we;
  logic [7:0]  w_mem_addr;
  logic [15:0] w_mem_wdata;

  assign w_op   = r_ir[15:12];
  assign w_rd   = r_ir[11:9];
  assign w_rs1  = r_ir[8:6];
  assign w_rs2  = r_ir[5:3];
  assign w_imm6 = {{10{r_ir[5]}}, r_ir[5:0]};
  assign w_imm8 = r_ir[7:0];

  assign w_a       = (w_rs1 == 3'd0) ? 16'd0 : r_regs[w_rs1];
  assign w_b       = (w_rs2 == 3'd0) ? 16'd0 : r_regs[w_rs2];
  assign w_d       = (w_rd == 3'd0) ? 16'd0 : r_regs[w_rd];
  assign dbg_rdata = (dbg_raddr == 3'd0) ? 16'd0 : r_regs[dbg_raddr];

  always_comb begin
    case (w_op)
      4'h1:    w_alu = w_a + w_b;
      4'h2:    w_alu = w_a - w_b;
      4'h3:    w_alu = w_a & w_b;
      4'h4:    w_alu = w_a | w_b;
      4'h5:    w_alu = w_a ^ w_b;
      default: w_alu = w_a + w_imm6;  // ADDI and LD/ST effective address
    endcase
  end

  always_comb begin
    w_state_d   = r_state;
    w_pc_d      = r_pc;
    w_ir_load   = 1'b0;
    w_rf_we     = 1'b0;
    w_rf_wdata  = w_alu;
    w_core_we   = 1'b0;
    w_core_addr = r_pc;
    unique case (r_state)
      StFetch:  w_state_d = StDecode;
      StDecode: begin
        w_ir_load = 1'b1;
        w_pc_d    = r_pc + 8'd1;
        w_state_d = StExecute;
      end
      StExecute: begin
        w_state_d = StFetch;
        case (w_op)
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: w_rf_we = 1'b1;
          4'h7: begin
            w_core_addr = w_alu[7:0];
            w_state_d   = StMemwb;
          end
          4'h8: begin
            w_core_addr = w_alu[7:0];
            w_core_we   = 1'b1;
          end
          4'h9: if (w_d == w_a) w_pc_d = r_pc + w_imm6[7:0];
          4'hA: w_pc_d = w_imm8;
          4'hF: w_state_d = StHalt;
          default: ;
        endcase
      end
      StMemwb: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = r_rdata;
        w_state_d  = StFetch;
      end
      StHalt:  w_state_d = StHalt;
      default: w_state_d = StFetch;
    endcase
  end

  // While reset is held the memory belongs to the program-load port.
  assign w_mem_we    = reset ? w_core_we : ext_we;
  assign w_mem_addr  = reset ? w_core_addr : ext_addr;
  assign w_mem_wdata = reset ? w_d : ext_wdata;

  always_ff @(posedge clock) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
    r_rdata <= r_mem[w_mem_addr];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= StFetch;
      r_pc    <= 8'd0;
      r_ir    <= 16'd0;
      for (int i = 0; i < 8; i++) r_regs[i] <= 16'd0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      if (w_ir_load) r_ir <= r_rdata;
      if (w_rf_we && (w_rd != 3'd0)) r_regs[w_rd] <= w_rf_wdata;
    end
  end

  assign pc   = r_pc;
  assign ir   = r_ir;
  assign halt = (r_state == StHalt);

`ifdef HALT_FINISH_EN
  always @(posedge clock) begin
    if (halt) begin
      $display("HLT instruction executed. CPU Halted at time %0t.", $time);
      $finish;
    end
  end
`else
`endif

endmodule

// File: tb/tb_von_neumann_core.sv
// Scoreboard bench: an instruction-level interpreter predicts each program's final state,
// and a monitor compares it when halt rises.
module tb_von_neumann_core;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ext_we = 1'b0;
  logic [7:0]  ext_addr = 8'd0;
  logic [15:0] ext_wdata = 16'd0;
  logic [2:0]  dbg_raddr = 3'd0;
  logic [15:0] dbg_rdata;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic        halt;

  always #10 clock = ~clock;

  von_neumann_core dut (
    .clock     (clock),
    .reset     (reset),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata),
    .pc        (pc),
    .ir        (ir),
    .halt      (halt)
  );

  typedef struct packed {
    logic [7:0][15:0] regs;
    logic [7:0]       pc;
    logic [15:0]      ir;
    logic [15:0]      cycles;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] img [256];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc;
  bit          done = 1'b0;
  bit          rst_req = 1'b0;

  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [5:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 3'b000};
  endfunction

  // Instruction-level interpreter over a private copy of img.
  task automatic model(output exp_t e, output bit ok);
    logic [15:0] mm [256];
    logic [15:0] rr [8];
    logic [7:0]  p, ea;
    logic [15:0] w, a, b, d, imm, res;
    int          cy;
    bit          wr;
    for (int i = 0; i < 256; i++) mm[i] = img[i];
    for (int i = 0; i < 8; i++) rr[i] = 16'd0;
    p = 8'd0; cy = 0; ok = 1'b0; e = '0; w = 16'd0;
    for (int s = 0; s < 200 && !ok; s++) begin
      w   = mm[p];
      a   = rr[w[8:6]];
      b   = rr[w[5:3]];
      d   = rr[w[11:9]];
      imm = {{10{w[5]}}, w[5:0]};
      ea  = a[7:0] + imm[7:0];
      p   = p + 8'd1;
      cy  += 3;
      wr  = 1'b0;
      res = 16'd0;
      case (w[15:12])
        4'h1: begin wr = 1'b1; res = a + b; end
        4'h2: begin wr = 1'b1; res = a - b; end
        4'h3: begin wr = 1'b1; res = a & b; end
        4'h4: begin wr = 1'b1; res = a | b; end
        4'h5: begin wr = 1'b1; res = a ^ b; end
        4'h6: begin wr = 1'b1; res = a + imm; end
        4'h7: begin wr = 1'b1; res = mm[ea]; cy += 1; end
        4'h8: mm[ea] = d;
        4'h9: if (d == a) p = p + imm[7:0];
        4'hA: p = w[7:0];
        4'hF: ok = 1'b1;
        default: ;
      endcase
      if (wr && (w[11:9] != 3'd0)) rr[w[11:9]] = res;
    end
    e.pc = p;
    e.ir = w;
    e.cycles = 16'(cy);
    for (int i = 0; i < 8; i++) e.regs[i] = rr[i];
  endtask

  initial begin : monitor
    bit   seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        seen = 1'b0;
        if (rst_req) begin
          for (int i = 0; i < 8; i++) begin
            dbg_raddr = 3'(i);
            #1;
            chk($sformatf("reset_r%0d", i), 32'(dbg_rdata), 32'd0);
          end
          rst_req = 1'b0;
        end
      end else if (halt && !seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_halt: halt seen at pc %h, no program outstanding", pc);
        end else begin
          e = exp_q.pop_front();
          chk("halt_cycles", 32'(cyc), 32'(e.cycles));
          chk("halt_pc", 32'(pc), 32'(e.pc));
          chk("halt_ir", 32'(ir), 32'(e.ir));
          for (int i = 0; i < 8; i++) begin
            dbg_raddr = 3'(i);
            #1;
            chk($sformatf("reg_r%0d", i), 32'(dbg_rdata), 32'(e.regs[i]));
          end
        end
        done = 1'b1;
      end
    end
  end

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      ext_addr  = 8'(i);
      ext_wdata = img[i];
      ext_we    = 1'b1;
      @(negedge clock);
    end
    ext_we = 1'b0;
  endtask

  task automatic run(input string tag, input int n_load);
    exp_t e;
    bit   ok;
    model(e, ok);
    if (!ok) begin
      $display("note: %s skipped, program does not terminate", tag);
      return;
    end
    @(negedge clock);
    reset = 1'b0;
    load(n_load);
    exp_q.push_back(e);
    done  = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < int'(e.cycles) + 40 && !done; k++) @(negedge clock);
    if (!done) begin
      n_chk++;
      $display("FAIL %s_timeout: halt not seen, required after %0d cycles", tag, e.cycles);
      exp_q.delete();
    end else begin
      repeat (4) @(negedge clock);
      chk({tag, "_halt_sticky"}, 32'(halt), 32'd1);
      chk({tag, "_pc_frozen"}, 32'(pc), 32'(e.pc));
    end
  endtask

  task automatic wait_rst_checks();
    rst_req = 1'b1;
    for (int k = 0; k < 20 && rst_req; k++) @(negedge clock);
    if (rst_req) begin
      n_chk++;
      $display("FAIL reset_reg_timeout: register checks not done, required within 20 cycles");
      rst_req = 1'b0;
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 16'd0;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not end, required to end before 3000000");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    exp_t e;
    bit   ok;
    @(negedge clock);
    chk("reset_pc", 32'(pc), 32'd0);
    chk("reset_ir", 32'(ir), 32'd0);
    chk("reset_halt", 32'(halt), 32'd0);
    wait_rst_checks();

    clear_img();
    img[0] = 16'h6205;
    img[1] = 16'h6443;
    img[2] = 16'hF000;
    run("addi_hlt", 256);

    clear_img();
    img[20] = 16'h00F0;
    img[21] = 16'h0F0F;
    img[0] = enc_i(4'h7, 3'd1, 3'd0, 6'd20);
    img[1] = enc_i(4'h7, 3'd2, 3'd0, 6'd21);
    img[2] = enc_r(4'h1, 3'd3, 3'd1, 3'd2);
    img[3] = enc_r(4'h2, 3'd4, 3'd1, 3'd2);
    img[4] = enc_r(4'h3, 3'd5, 3'd1, 3'd2);
    img[5] = enc_r(4'h4, 3'd6, 3'd1, 3'd2);
    img[6] = enc_r(4'h5, 3'd7, 3'd1, 3'd2);
    img[7] = 16'hF000;
    run("alu", 256);

    clear_img();
    img[10] = 16'h1234;
    img[11] = 16'h0080;
    img[0] = enc_i(4'h7, 3'd1, 3'd0, 6'd10);
    img[1] = enc_i(4'h7, 3'd2, 3'd0, 6'd11);
    img[2] = enc_i(4'h8, 3'd1, 3'd2, 6'd0);
    img[3] = enc_i(4'h7, 3'd3, 3'd2, 6'd0);
    img[4] = enc_i(4'h7, 3'd4, 3'd0, 6'd0);
    img[5] = 16'hF000;
    run("mem_rt", 256);

    clear_img();
    img[0] = enc_i(4'h6, 3'd4, 3'd0, 6'd1);
    img[1] = enc_i(4'h6, 3'd3, 3'd3, 6'd1);
    img[2] = enc_i(4'h9, 3'd3, 3'd4, 6'h3E);
    img[3] = 16'hF000;
    run("beq_back", 256);

    clear_img();
    img[0]    = enc_i(4'h9, 3'd1, 3'd0, 6'd1);
    img[1]    = 16'hF000;
    img[2]    = enc_i(4'h6, 3'd1, 3'd0, 6'd1);
    img[3]    = {4'hA, 4'h0, 8'hFF};
    img[255]  = 16'h0000;
    run("jmp_wrap", 256);

    clear_img();
    img[0]    = {4'hA, 4'h0, 8'h10};
    img[16'h10] = 16'hF000;
    run("jmp_10", 256);

    clear_img();
    img[0] = enc_i(4'h6, 3'd0, 3'd0, 6'd7);
    img[1] = 16'hC249;
    img[2] = 16'hF000;
    run("r0_undef", 256);

    // Abort a store in EXECUTE, then read its target back through a fresh program.
    clear_img();
    img[0]  = enc_i(4'h6, 3'd1, 3'd0, 6'd5);
    img[1]  = enc_i(4'h8, 3'd1, 3'd0, 6'd31);
    img[2]  = 16'hF000;
    img[31] = 16'hBEEF;
    @(negedge clock);
    reset = 1'b0;
    load(256);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    chk("abort_ir_is_st", 32'(ir), 32'(img[1]));
    reset = 1'b0;
    #1;
    chk("abort_pc", 32'(pc), 32'd0);
    chk("abort_ir", 32'(ir), 32'd0);
    chk("abort_halt", 32'(halt), 32'd0);
    wait_rst_checks();
    img[0] = enc_i(4'h7, 3'd2, 3'd0, 6'd31);
    img[1] = 16'hF000;
    run("abort_reload", 2);

    for (int t = 0; t < 12; t++) begin
      ok = 1'b0;
      for (int tries = 0; tries < 50 && !ok; tries++) begin
        for (int i = 0; i < 256; i++) img[i] = 16'($urandom);
        for (int i = 0; i < 16; i++) if (img[i][15:12] == 4'hF) img[i][15:12] = 4'h6;
        for (int i = 16; i < 24; i++) img[i] = 16'hF000;
        model(e, ok);
      end
      run($sformatf("rand%0d", t), 256);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
